// File: rtl/key_event_fifo.sv
// key_event_fifo: turns key presses into events and buffers them in a first-word-fall-through FIFO (auto-repeat when KEY_REPEAT_EN is defined)
module key_event_fifo #(
   parameter int DEPTH         = 8,
   parameter int CW            = 4,
   parameter int HOLD_CYCLES   = 16,
   parameter int REPEAT_CYCLES = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid,
   input  logic [CW-1:0]              code,
   input  logic                       rd_en,
   input  logic                       clr_ovf,
   output logic [CW-1:0]              rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;
   localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("key_event_fifo: DEPTH must be a power of two >= 2 and repeat intervals >= 1");
   end

   logic [CW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [NW-1:0] r_count;
   logic          r_ovf;
   logic          r_prev_valid;
   logic [CW-1:0] r_prev_code;
   logic          w_rep;
   logic          w_evt;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;

`ifdef KEY_REPEAT_EN
   localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RW   = $clog2(RMAX) + 1;
   logic [RW-1:0] r_rep_cnt;
   logic          r_rep_phase;
   logic          w_hold;
   assign w_hold = valid & r_prev_valid & (code == r_prev_code);
   assign w_rep  = w_hold & (r_rep_cnt == (r_rep_phase ? RW'(REPEAT_CYCLES - 1) : RW'(HOLD_CYCLES - 1)));

   // Hold timer: first repeat after HOLD_CYCLES, then every REPEAT_CYCLES; any event or release restarts it
   always_ff @(posedge clk) begin
      if (rst || !w_hold) begin
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b0;
      end else if (w_rep) begin
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b1;
      end else begin
         r_rep_cnt <= r_rep_cnt + 1'b1;
      end
   end
`else
   assign w_rep = 1'b0;
`endif

   assign w_evt  = (valid & (~r_prev_valid | (code != r_prev_code))) | w_rep;
   assign w_pop  = rd_en & (r_count != '0);
   assign w_push = w_evt & ((r_count != FULL_CNT) | w_pop);
   assign w_drop = w_evt & ~w_push;

   // Pointers, occupancy, sticky overflow and the previous-sample registers used for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_ovf        <= 1'b0;
         r_prev_valid <= 1'b0;
         r_prev_code  <= '0;
      end else begin
         r_wr_ptr     <= r_wr_ptr + AW'(w_push);
         r_rd_ptr     <= r_rd_ptr + AW'(w_pop);
         r_count      <= r_count + NW'(w_push) - NW'(w_pop);
         r_ovf        <= w_drop | (r_ovf & ~clr_ovf);
         r_prev_valid <= valid;
         r_prev_code  <= code;
      end
   end

   // Storage array; contents need no reset since the pointers define what is valid
   always_ff @(posedge clk) begin
      if (!rst && w_push) r_mem[r_wr_ptr] <= code;
   end

   assign empty    = (r_count == '0);
   assign full     = (r_count == FULL_CNT);
   assign count    = r_count;
   assign overflow = r_ovf;
   assign rd_data  = empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
Sits directly downstream of the keypad scanner and consumes its valid/code outputs. Turns each new key press into a single event and buffers the 4-bit key codes in a small first-word-fall-through FIFO. The host or display logic drains the FIFO through a read-enable handshake. Overflow is reported by a sticky flag.

Parameters:
DEPTH, 8, number of FIFO entries; must be a power of two, minimum 2
CW, 4, key code width in bits
HOLD_CYCLES, 16, cycles a key is held before the first auto-repeat (used only with KEY_REPEAT_EN)
REPEAT_CYCLES, 8, cycles between later auto-repeats (used only with KEY_REPEAT_EN)

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous reset, active-high
valid  input  1  scanner reports a key pressed this cycle
code  input  CW  scanner key code; meaningful only while valid=1
rd_en  input  1  pop the head entry; ignored while empty=1
clr_ovf  input  1  clears the overflow flag
rd_data  output  CW  head entry (FWFT); holds 0 while empty
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds DEPTH entries
count  output  $clog2(DEPTH)+1  number of stored entries
overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at an edge) clears:
  - pointers, count and the overflow flag
  - prev_valid and prev_code (both 0)
  - auto-repeat counter
  - Resulting outputs: empty=1, full=0, count=0, overflow=0, rd_data=0.
  - Memory contents are don't-care.
  - Reset takes priority over every other input in the same cycle.
- Event detection uses registers prev_valid and prev_code, updated every cycle. An event fires when either:
  - valid=1 and prev_valid=0 (new press), or
  - valid=1, prev_valid=1 and code!=prev_code (key change without release).
- A held key with an unchanged code produces no further events unless KEY_REPEAT_EN is defined. Release (valid=0) produces no event.
- Push: on an event edge, the current code is written at wr_ptr.
  - Latency: valid rises before edge k; after edge k, empty=0 and rd_data=code.
- Pop: on an edge with rd_en=1 and empty=0, rd_ptr advances. rd_data combinationally shows the new head, or 0 if the FIFO becomes empty.
- Simultaneous push and pop:
  - Not full and not empty: both take effect; count is unchanged.
  - Empty: the pop is ignored and the push succeeds (count 0->1).
  - Full: the pop frees a slot, so the push succeeds; count stays DEPTH and overflow is not set.
- Push while full with no pop:
  - The event is dropped and the contents are unchanged.
  - overflow=1 from the next edge.
- clr_ovf=1 clears overflow at the edge. If a drop happens in the same cycle, the set wins.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. count is maintained explicitly:
  - full = (count==DEPTH)
  - empty = (count==0)

Optional Feature:
KEY_REPEAT_EN
- Defined: a counter clears on every event and increments while valid=1 with an unchanged code.
  - When it reaches HOLD_CYCLES, a repeat event pushes the same code.
  - After that, a repeat event fires every REPEAT_CYCLES cycles while the key is held.
  - The counter resets on release or on a code change.
  - Repeat events follow the same full/overflow rules as ordinary events.
- Not defined: no counter logic is generated, and a held key yields exactly one event.

Test Plan:
- Reset, then idle -> empty=1, full=0, count=0, overflow=0, rd_data=0.
- valid=1 code=5 held 6 cycles, then released -> exactly one entry; rd_data=5, count=1. With rd_en=1 for one cycle -> empty=1.
- Presses of 3, 7, 0xA with release between each, then pop three times -> rd_data reads 3, 7, 0xA in order; count steps 3,2,1,0.
- 9 separate presses (codes 0..8), DEPTH=8, no reads -> full=1 after the 8th; overflow=1 after the 9th; draining yields 0..7; clr_ovf clears overflow.
- FIFO full (count=8), new press with rd_en=1 on the same edge -> count stays 8, overflow=0, the new code appears at the tail.
- KEY_REPEAT_EN with HOLD_CYCLES=16, REPEAT_CYCLES=8, code=2 held 40 cycles -> 4 entries, all 2: the press plus repeats at 16, 24 and 32 cycles after it. Without the macro -> 1 entry.
